// File: rtl/cfg_reg_file_hs.sv
// Parametrised configuration register file with per-bit write masks and a
// registered valid/ready response port for read data and optional write acks.
module cfg_reg_file_hs #(
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 24,
    parameter int PKT_W    = 3 + ADDR_W + DATA_W,
    parameter logic [NUM_REGS-1:0][DATA_W-1:0] RESET_VALS  = '0,
    parameter logic [NUM_REGS-1:0][DATA_W-1:0] WRITE_MASKS = '1,
    parameter bit WRITE_ACK = 1'b0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [PKT_W-1:0]                   packet,
    input  logic                               cfg_read_en,
    input  logic                               cfg_write_en,
    output logic                               cmd_ready,
    output logic [2+ADDR_W+DATA_W-1:0]         resp_data,
    output logic                               resp_valid,
    input  logic                               resp_ready,
    output logic [NUM_REGS-1:0][DATA_W-1:0]    all_regs,
    output logic [NUM_REGS-1:0]                reg_changed
);

    logic [ADDR_W-1:0]               addr;
    logic [DATA_W-1:0]               data;
    logic [PKT_W-ADDR_W-DATA_W-1:0]  hdr_unused;
    logic                            accept;
    logic                            in_range;
    logic                            resp_gen;
    logic [DATA_W-1:0]               cur_val;
    logic [DATA_W-1:0]               cur_mask;
    logic [DATA_W-1:0]               new_val;
    logic [2+ADDR_W+DATA_W-1:0]      resp_next;

    assign addr       = packet[DATA_W +: ADDR_W];
    assign data       = packet[DATA_W-1:0];
    assign hdr_unused = packet[PKT_W-1:ADDR_W+DATA_W];

    // Single response slot: a new command may land in the same edge the old one drains.
    assign cmd_ready = !rst && (!resp_valid || resp_ready);
    assign accept    = (cfg_read_en || cfg_write_en) && cmd_ready;
    assign resp_gen  = cfg_read_en || (cfg_write_en && WRITE_ACK);

    always_comb begin
        cur_val  = '0;
        cur_mask = '0;
        in_range = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == ADDR_W'(i)) begin
                cur_val  = all_regs[i];
                cur_mask = WRITE_MASKS[i];
                in_range = 1'b1;
            end
        end
        new_val = (cur_val & ~cur_mask) | (data & cur_mask);

        // Read+write returns the post-write value under the read tag.
        if (!in_range)
            resp_next = {2'b01, addr, {DATA_W{1'b0}}};
        else if (cfg_write_en)
            resp_next = {(cfg_read_en ? 2'b10 : 2'b11), addr, new_val};
        else
            resp_next = {2'b10, addr, cur_val};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            all_regs    <= RESET_VALS;
            resp_valid  <= 1'b0;
            resp_data   <= '0;
            reg_changed <= '0;
        end else begin
            reg_changed <= '0;
            if (resp_valid && resp_ready)
                resp_valid <= 1'b0;
            if (accept) begin
                if (cfg_write_en) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (addr == ADDR_W'(i)) begin
                            all_regs[i]    <= new_val;
                            reg_changed[i] <= 1'b1;
                        end
                    end
                end
                if (resp_gen) begin
                    resp_valid <= 1'b1;
                    resp_data  <= resp_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_cfg_reg_file_hs.sv
// Bench for cfg_reg_file_hs: two configurations (6 regs no-ack, 8 regs with ack)
// share one stimulus stream and are compared against a register-array model.
module tb_cfg_reg_file_hs;

    logic        clk;
    logic        rst;
    logic [28:0] packet;
    logic        cfg_read_en;
    logic        cfg_write_en;
    logic        resp_ready;

    logic             a_ready, a_valid;
    logic [28:0]      a_data;
    logic [5:0][23:0] a_regs;
    logic [5:0]       a_chg;
    logic             b_ready, b_valid;
    logic [28:0]      b_data;
    logic [7:0][23:0] b_regs;
    logic [7:0]       b_chg;

    int n_chk  = 0;
    int n_fail = 0;

    cfg_reg_file_hs #(
        .ADDR_W(3), .NUM_REGS(6), .DATA_W(24),
        .RESET_VALS ({24'h0, 24'h0, 24'h00ABCD, 24'hAA0000, 24'h0, 24'h0}),
        .WRITE_MASKS({24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h0000FF, 24'hFFFFFF, 24'hFFFFFF}),
        .WRITE_ACK(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst), .packet(packet),
        .cfg_read_en(cfg_read_en), .cfg_write_en(cfg_write_en),
        .cmd_ready(a_ready), .resp_data(a_data), .resp_valid(a_valid),
        .resp_ready(resp_ready), .all_regs(a_regs), .reg_changed(a_chg)
    );

    cfg_reg_file_hs #(
        .ADDR_W(3), .NUM_REGS(8), .DATA_W(24),
        .RESET_VALS ({24'h0, 24'h0, 24'h0, 24'h0, 24'h00ABCD, 24'hAA0000, 24'h0, 24'h0}),
        .WRITE_MASKS({24'hFFFFFF, 24'hF0F0F0, 24'hFFFFFF, 24'hFFFFFF,
                      24'hFFFFFF, 24'h0000FF, 24'hFFFFFF, 24'hFFFFFF}),
        .WRITE_ACK(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .packet(packet),
        .cfg_read_en(cfg_read_en), .cfg_write_en(cfg_write_en),
        .cmd_ready(b_ready), .resp_data(b_data), .resp_valid(b_valid),
        .resp_ready(resp_ready), .all_regs(b_regs), .reg_changed(b_chg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [23:0] m_reg [2][8];
    logic        m_rv  [2];
    logic [28:0] m_rd  [2];
    logic [7:0]  m_chg [2];

    function automatic int nreg_of(int d);
        return (d == 0) ? 6 : 8;
    endfunction

    function automatic logic [23:0] rv_of(int i);
        if (i == 2) return 24'hAA0000;
        if (i == 3) return 24'h00ABCD;
        return 24'h0;
    endfunction

    function automatic logic [23:0] mask_of(int d, int i);
        if (i == 2) return 24'h0000FF;
        if (d == 1 && i == 6) return 24'hF0F0F0;
        return 24'hFFFFFF;
    endfunction

    task automatic mreset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) m_reg[d][i] = rv_of(i);
            m_rv[d]  = 1'b0;
            m_rd[d]  = '0;
            m_chg[d] = '0;
        end
    endtask

    task automatic mstep();
        for (int d = 0; d < 2; d++) begin
            logic        rdy, ok;
            int          a;
            logic [23:0] wd, mk;
            rdy      = !m_rv[d] || resp_ready;
            m_chg[d] = '0;
            if (m_rv[d] && resp_ready) m_rv[d] = 1'b0;
            if ((cfg_read_en || cfg_write_en) && rdy) begin
                a  = int'(packet[26:24]);
                wd = packet[23:0];
                ok = a < nreg_of(d);
                mk = mask_of(d, a);
                if (cfg_write_en && ok) begin
                    m_reg[d][a] = (m_reg[d][a] & ~mk) | (wd & mk);
                    m_chg[d][a] = 1'b1;
                end
                if (cfg_read_en || (cfg_write_en && d == 1)) begin
                    m_rv[d] = 1'b1;
                    if (!ok)
                        m_rd[d] = {2'b01, 3'(a), 24'h0};
                    else
                        m_rd[d] = {(cfg_read_en ? 2'b10 : 2'b11), 3'(a), m_reg[d][a]};
                end
            end
        end
    endtask

    initial begin
        mreset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) mreset();
            else     mstep();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("a_ready", 32'(a_ready), 32'(!rst && (!m_rv[0] || resp_ready)));
            chk("a_valid", 32'(a_valid), 32'(m_rv[0]));
            if (m_rv[0]) chk("a_data", 32'(a_data), 32'(m_rd[0]));
            chk("a_chg", 32'(a_chg), 32'(m_chg[0][5:0]));
            for (int i = 0; i < 6; i++) chk($sformatf("a_reg%0d", i), 32'(a_regs[i]), 32'(m_reg[0][i]));
            chk("b_ready", 32'(b_ready), 32'(!rst && (!m_rv[1] || resp_ready)));
            chk("b_valid", 32'(b_valid), 32'(m_rv[1]));
            if (m_rv[1]) chk("b_data", 32'(b_data), 32'(m_rd[1]));
            chk("b_chg", 32'(b_chg), 32'(m_chg[1]));
            for (int i = 0; i < 8; i++) chk($sformatf("b_reg%0d", i), 32'(b_regs[i]), 32'(m_reg[1][i]));
        end
    end

    // ---------------- directed table (config A constants) ----------------
    typedef struct {
        logic        re;
        logic        we;
        logic [2:0]  addr;
        logic [23:0] data;
        logic        exp_valid;
        logic [28:0] exp_data;
        logic [5:0]  exp_chg;
        int          ridx;
        logic [23:0] exp_reg;
    } vec_t;

    vec_t tbl [8];

    task automatic drive(input logic re, input logic we, input logic [2:0] ad, input logic [23:0] dt);
        cfg_read_en  = re;
        cfg_write_en = we;
        packet       = {3'b101, ad, dt};
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b1, 3'd5, 24'h123456, 1'b0, 29'h0,                        6'h20, 5, 24'h123456};
        tbl[1] = '{1'b1, 1'b0, 3'd5, 24'h000000, 1'b1, {2'b10, 3'd5, 24'h123456},    6'h00, 5, 24'h123456};
        tbl[2] = '{1'b0, 1'b1, 3'd2, 24'h5555FF, 1'b0, 29'h0,                        6'h04, 2, 24'hAA00FF};
        tbl[3] = '{1'b1, 1'b0, 3'd2, 24'h000000, 1'b1, {2'b10, 3'd2, 24'hAA00FF},    6'h00, 3, 24'h00ABCD};
        tbl[4] = '{1'b1, 1'b0, 3'd7, 24'h777777, 1'b1, {2'b01, 3'd7, 24'h000000},    6'h00, 4, 24'h000000};
        tbl[5] = '{1'b0, 1'b1, 3'd6, 24'hFFFFFF, 1'b0, 29'h0,                        6'h00, 5, 24'h123456};
        tbl[6] = '{1'b1, 1'b0, 3'd3, 24'h000000, 1'b1, {2'b10, 3'd3, 24'h00ABCD},    6'h00, 0, 24'h000000};
        tbl[7] = '{1'b1, 1'b1, 3'd0, 24'h000042, 1'b1, {2'b10, 3'd0, 24'h000042},    6'h01, 0, 24'h000042};

        rst = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 24'h0);
        resp_ready = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_a_valid", 32'(a_valid), 32'd0);
        chk("rst_a_data",  32'(a_data),  32'd0);
        chk("rst_a_chg",   32'(a_chg),   32'd0);
        chk("rst_a_reg3",  32'(a_regs[3]), 32'h00ABCD);
        chk("rst_a_reg2",  32'(a_regs[2]), 32'hAA0000);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        chk("rst_b_reg3",  32'(b_regs[3]), 32'h00ABCD);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            drive(tbl[k].re, tbl[k].we, tbl[k].addr, tbl[k].data);
            @(posedge clk); #1;
            drive(1'b0, 1'b0, 3'd0, 24'h0);
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", k), 32'(a_valid), 32'(tbl[k].exp_valid));
            if (tbl[k].exp_valid)
                chk($sformatf("tbl%0d_data", k), 32'(a_data), 32'(tbl[k].exp_data));
            chk($sformatf("tbl%0d_chg", k), 32'(a_chg), 32'(tbl[k].exp_chg));
            chk($sformatf("tbl%0d_reg", k), 32'(a_regs[tbl[k].ridx]), 32'(tbl[k].exp_reg));
        end

        // Backpressure: read 1 stalls with resp_ready low while a read of 2 waits.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 3'd1, 24'h0BEEF1);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 3'd1, 24'h0);
        resp_ready = 1'b0;
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 3'd2, 24'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_ready", 32'(a_ready), 32'd0);
            chk("bp_valid", 32'(a_valid), 32'd1);
            chk("bp_data",  32'(a_data),  32'({2'b10, 3'd1, 24'h0BEEF1}));
            @(posedge clk);
        end
        #1 resp_ready = 1'b1;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'd0, 24'h0);
        @(negedge clk);
        chk("bp_next_valid", 32'(a_valid), 32'd1);
        chk("bp_next_data",  32'(a_data),  32'({2'b10, 3'd2, 24'hAA00FF}));

        // Reset while a read+write response is pending.
        @(posedge clk); #1;
        resp_ready = 1'b0;
        drive(1'b1, 1'b1, 3'd0, 24'h000042);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'd0, 24'h0);
        @(negedge clk);
        chk("rw_valid", 32'(a_valid), 32'd1);
        chk("rw_data",  32'(a_data),  32'({2'b10, 3'd0, 24'h000042}));
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(a_valid), 32'd0);
        chk("midrst_ready", 32'(a_ready), 32'd0);
        chk("midrst_reg0",  32'(a_regs[0]), 32'd0);
        chk("midrst_reg1",  32'(a_regs[1]), 32'd0);
        chk("midrst_b_valid", 32'(b_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        resp_ready = 1'b1;

        // Random traffic against the model, with one reset pulse midway.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            rst = (n == 1500);
            drive(($urandom % 3) == 0, ($urandom % 4) == 0,
                  3'($urandom_range(0, 7)), 24'($urandom));
            resp_ready = ($urandom % 4) != 0;
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'd0, 24'h0);
        @(negedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
